// File: rtl/gray_ptr_fifo_pkg.sv
// Shared helpers for the gray-pointer FIFO.
//   b2g_converter / g2b_converter : binary <-> gray conversion on a pointer
//                                   up to PTR_MAX_W bits wide (zero-extend narrower values).
//   byte_swap                     : reverses the byte order of the low nbytes bytes of a word
//                                   (generalised form of a 32-bit endian reverse).
//   full_cmp_mask                 : mask with the top two bits of a w-bit gray pointer set;
//                                   XORing a gray read pointer with it gives the "full" pattern.
package gray_ptr_fifo_pkg;

    localparam int PTR_MAX_W  = 9;     // DEPTH_LOG2 max 8, plus one wrap bit
    localparam int MAX_DATA_W = 1024;  // widest word byte_swap handles

    function automatic logic [PTR_MAX_W-1:0] b2g_converter(input logic [PTR_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] g2b_converter(input logic [PTR_MAX_W-1:0] gray);
        logic [PTR_MAX_W-1:0] bin;
        bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    function automatic logic [MAX_DATA_W-1:0] byte_swap(input logic [MAX_DATA_W-1:0] d,
                                                        input int nbytes);
        logic [MAX_DATA_W-1:0] r;
        r = '0;
        for (int k = 0; k < MAX_DATA_W / 8; k++) begin
            if (k < nbytes) begin
                r[k*8 +: 8] = d[(nbytes-1-k)*8 +: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [PTR_MAX_W-1:0] full_cmp_mask(input int w);
        logic [PTR_MAX_W-1:0] m;
        m = '0;
        m[w-1] = 1'b1;
        m[w-2] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/gray_ptr_fifo_gray_ptr.sv
// gray_ptr: W-bit wrapping pointer kept in both binary and gray form.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : synchronous clear to zero (wins over inc)
//   inc          : advance the pointer by one, wrapping modulo 2**W
//   bin, gray    : registered binary and gray values; gray is computed from the
//                  next binary value so both update on the same edge.
module gray_ptr
    import gray_ptr_fifo_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] bin,
    output logic [W-1:0] gray
);

    if (W < 2 || W > PTR_MAX_W) begin : g_bad_w
        $error("gray_ptr: W must be in 2..%0d", PTR_MAX_W);
    end

    logic [W-1:0] bin_q, bin_d;
    logic [W-1:0] gray_q, gray_d;

    always_comb begin
        bin_d = bin_q;
        if (clr) begin
            bin_d = '0;
        end else if (inc) begin
            bin_d = bin_q + W'(1);
        end
        gray_d = W'(b2g_converter(PTR_MAX_W'(bin_d)));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
        end
    end

    assign bin  = bin_q;
    assign gray = gray_q;

endmodule

// File: rtl/gray_ptr_fifo.sv
// gray_ptr_fifo: single-clock first-word-fall-through FIFO with gray-coded pointers.
//   clk, reset_n          : clock, asynchronous active-low reset
//   flush                 : synchronous clear; beats any read/write in the same cycle
//   wr_valid/wr_ready/wr_data : write side; a word is taken when wr_valid && wr_ready at posedge
//   rd_valid/rd_ready/rd_data : read side; head word is consumed when rd_valid && rd_ready at posedge
//   level                 : stored word count, 0..2**DEPTH_LOG2
//   almost_full           : level >= AFULL_THRESH (registered)
//   wr_ptr_gray/rd_ptr_gray : gray pointers with wrap bit, exported for a later CDC split
// Handshake: valid and ready are independent; a transfer happens on any edge where both
// are high. wr_ready and rd_valid come only from registered pointers, never from the
// opposite handshake input, so there is no combinational path through the FIFO.
module gray_ptr_fifo
    import gray_ptr_fifo_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int DEPTH_LOG2   = 4,
    parameter int AFULL_THRESH = 12,
    parameter int SWAP_BYTES   = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [WIDTH-1:0]      wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [WIDTH-1:0]      rd_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  almost_full,
    output logic [DEPTH_LOG2:0]   wr_ptr_gray,
    output logic [DEPTH_LOG2:0]   rd_ptr_gray
);

    localparam int AW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 8) begin : g_bad_depth
        $error("gray_ptr_fifo: DEPTH_LOG2 must be in 1..8");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_thresh
        $error("gray_ptr_fifo: AFULL_THRESH must be in 1..2**DEPTH_LOG2");
    end
    if (SWAP_BYTES != 0 && SWAP_BYTES != 1) begin : g_bad_swap
        $error("gray_ptr_fifo: SWAP_BYTES must be 0 or 1");
    end
    if (SWAP_BYTES == 1 && ((WIDTH % 8) != 0 || WIDTH > MAX_DATA_W)) begin : g_bad_width
        $error("gray_ptr_fifo: WIDTH must be a multiple of 8 (max %0d) when SWAP_BYTES=1",
               MAX_DATA_W);
    end

    localparam logic [AW-1:0] FULL_MASK = AW'(full_cmp_mask(AW));
    localparam logic [AW-1:0] AFULL_LVL = AW'(AFULL_THRESH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_bin, wr_gray, rd_bin, rd_gray;
    logic [AW-1:0] wr_bin_nxt, rd_bin_nxt;
    logic [AW-1:0] level_q, level_d;
    logic          afull_q, afull_d;
    logic          full, empty, wr_en, rd_en;

    // Full: write pointer is exactly one lap ahead, which in gray form means the
    // top two bits differ and the rest match.
    assign empty = (wr_gray == rd_gray);
    assign full  = (wr_gray == (rd_gray ^ FULL_MASK));

    assign wr_en = wr_valid && !full  && !flush;
    assign rd_en = rd_ready && !empty && !flush;

    gray_ptr #(.W(AW)) u_wr_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (flush),
        .inc     (wr_en),
        .bin     (wr_bin),
        .gray    (wr_gray)
    );

    gray_ptr #(.W(AW)) u_rd_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (flush),
        .inc     (rd_en),
        .bin     (rd_bin),
        .gray    (rd_gray)
    );

    // Mirror the pointers' next values so level and almost_full land on the same edge.
    always_comb begin
        wr_bin_nxt = flush ? '0 : wr_bin + AW'(wr_en);
        rd_bin_nxt = flush ? '0 : rd_bin + AW'(rd_en);
        level_d    = wr_bin_nxt - rd_bin_nxt;
        afull_d    = (level_d >= AFULL_LVL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= '0;
            afull_q <= 1'b0;
        end else begin
            level_q <= level_d;
            afull_q <= afull_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_bin[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

    logic [WIDTH-1:0] head_word;
    assign head_word = mem_q[rd_bin[DEPTH_LOG2-1:0]];

    if (SWAP_BYTES == 1) begin : g_swap
        assign rd_data = WIDTH'(byte_swap(MAX_DATA_W'(head_word), WIDTH / 8));
    end else begin : g_noswap
        assign rd_data = head_word;
    end

    assign wr_ready    = !full;
    assign rd_valid    = !empty;
    assign level       = level_q;
    assign almost_full = afull_q;
    assign wr_ptr_gray = wr_gray;
    assign rd_ptr_gray = rd_gray;

endmodule

// File: tb/tb_gray_ptr_fifo.sv
module tb_gray_ptr_fifo;

  localparam int W   = 32;
  localparam int DL2 = 2;
  localparam int DEP = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  // main DUT (no swap)
  logic          flush = 1'b0, wr_valid = 1'b0, rd_ready = 1'b0;
  logic [W-1:0]  wr_data = '0;
  logic          wr_ready, rd_valid, almost_full;
  logic [W-1:0]  rd_data;
  logic [DL2:0]  level, wr_ptr_gray, rd_ptr_gray;

  gray_ptr_fifo #(.WIDTH(W), .DEPTH_LOG2(DL2), .AFULL_THRESH(3), .SWAP_BYTES(0)) u_dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .level(level), .almost_full(almost_full),
    .wr_ptr_gray(wr_ptr_gray), .rd_ptr_gray(rd_ptr_gray)
  );

  // byte-swap DUT
  logic          s_flush = 1'b0, s_wr_valid = 1'b0, s_rd_ready = 1'b0;
  logic [W-1:0]  s_wr_data = '0;
  logic          s_wr_ready, s_rd_valid, s_almost_full;
  logic [W-1:0]  s_rd_data;
  logic [DL2:0]  s_level, s_wr_ptr_gray, s_rd_ptr_gray;

  gray_ptr_fifo #(.WIDTH(W), .DEPTH_LOG2(DL2), .AFULL_THRESH(3), .SWAP_BYTES(1)) u_swap (
    .clk(clk), .reset_n(reset_n), .flush(s_flush),
    .wr_valid(s_wr_valid), .wr_ready(s_wr_ready), .wr_data(s_wr_data),
    .rd_valid(s_rd_valid), .rd_ready(s_rd_ready), .rd_data(s_rd_data),
    .level(s_level), .almost_full(s_almost_full),
    .wr_ptr_gray(s_wr_ptr_gray), .rd_ptr_gray(s_rd_ptr_gray)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [DL2:0] m_wr_bin = '0, m_rd_bin = '0;
  int checks = 0;
  int passed = 0;

  function automatic logic [DL2:0] to_gray(input logic [DL2:0] b);
    return b ^ (b >> 1);
  endfunction

  // One clock: model the transfer from the current inputs, check the head word
  // on reads, advance the edge, then check every flag against the model.
  task automatic tick();
    bit do_wr, do_rd;
    logic [W-1:0] exp;
    do_wr = wr_valid && (exp_q.size() < DEP) && !flush;
    do_rd = rd_ready && (exp_q.size() > 0) && !flush;
    if (do_rd) begin
      exp = exp_q.pop_front();
      checks++;
      if (rd_data !== exp) $display("FAIL rd_data: got %h want %h", rd_data, exp);
      else passed++;
    end
    if (flush) begin
      exp_q.delete();
      m_wr_bin = '0;
      m_rd_bin = '0;
    end else begin
      if (do_wr) begin
        exp_q.push_back(wr_data);
        m_wr_bin = m_wr_bin + 1'b1;
      end
      if (do_rd) m_rd_bin = m_rd_bin + 1'b1;
    end
    @(posedge clk);
    #1;
    checks++;
    if (level !== (DL2+1)'(exp_q.size())) $display("FAIL level: got %0d want %0d", level, exp_q.size());
    else passed++;
    checks++;
    if (rd_valid !== (exp_q.size() != 0)) $display("FAIL rd_valid: got %b want %b", rd_valid, exp_q.size() != 0);
    else passed++;
    checks++;
    if (wr_ready !== (exp_q.size() != DEP)) $display("FAIL wr_ready: got %b want %b", wr_ready, exp_q.size() != DEP);
    else passed++;
    checks++;
    if (almost_full !== (exp_q.size() >= 3)) $display("FAIL almost_full: got %b want %b", almost_full, exp_q.size() >= 3);
    else passed++;
    checks++;
    if (wr_ptr_gray !== to_gray(m_wr_bin)) $display("FAIL wr_ptr_gray: got %b want %b", wr_ptr_gray, to_gray(m_wr_bin));
    else passed++;
    checks++;
    if (rd_ptr_gray !== to_gray(m_rd_bin)) $display("FAIL rd_ptr_gray: got %b want %b", rd_ptr_gray, to_gray(m_rd_bin));
    else passed++;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #3;
    checks++;
    if (level !== 3'd0 || rd_valid !== 1'b0 || wr_ready !== 1'b1 || almost_full !== 1'b0)
      $display("FAIL reset_flags: got lvl=%0d rv=%b wr=%b af=%b want 0/0/1/0", level, rd_valid, wr_ready, almost_full);
    else passed++;
    checks++;
    if (wr_ptr_gray !== 3'b000 || rd_ptr_gray !== 3'b000)
      $display("FAIL reset_ptrs: got %b/%b want 000/000", wr_ptr_gray, rd_ptr_gray);
    else passed++;
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    rd_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wr_valid = 1'b1;
      wr_data  = 32'h11223344 + k;
      tick();
    end
    checks++;
    if (wr_ready !== 1'b0 || level !== 3'd4) $display("FAIL fill_full: got wr=%b lvl=%0d want 0/4", wr_ready, level);
    else passed++;
    checks++;
    if (wr_ptr_gray !== 3'b110 || rd_ptr_gray !== 3'b000)
      $display("FAIL fill_ptrs: got %b/%b want 110/000", wr_ptr_gray, rd_ptr_gray);
    else passed++;
    // write offered while full is refused
    wr_data = 32'hDEADBEEF;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic test_drain();
    rd_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    rd_ready = 1'b0;
    checks++;
    if (rd_valid !== 1'b0 || level !== 3'd0) $display("FAIL drain_empty: got rv=%b lvl=%0d want 0/0", rd_valid, level);
    else passed++;
    checks++;
    if (wr_ptr_gray !== 3'b110 || rd_ptr_gray !== 3'b110)
      $display("FAIL drain_ptrs: got %b/%b want 110/110", wr_ptr_gray, rd_ptr_gray);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [DL2:0] prev_w, prev_r;
    bit seen_wrap;
    seen_wrap = 1'b0;
    wr_valid = 1'b1;
    rd_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      prev_w  = wr_ptr_gray;
      prev_r  = rd_ptr_gray;
      wr_data = $urandom;
      tick();
      if (prev_w == 3'b100 && wr_ptr_gray == 3'b000) seen_wrap = 1'b1;
      checks++;
      if ($countones(prev_w ^ wr_ptr_gray) > 1 || $countones(prev_r ^ rd_ptr_gray) > 1)
        $display("FAIL gray_step: got w %b->%b r %b->%b want single-bit steps", prev_w, wr_ptr_gray, prev_r, rd_ptr_gray);
      else passed++;
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    checks++;
    if (level !== 3'd1) $display("FAIL b2b_level: got %0d want 1", level);
    else passed++;
    checks++;
    if (!seen_wrap) $display("FAIL b2b_wrap: got no 100->000 step want one");
    else passed++;
  endtask

  task automatic test_almost_full();
    // level 1 -> 2 -> 3 -> 2
    wr_valid = 1'b1;
    wr_data  = $urandom;
    tick();
    checks++;
    if (level !== 3'd2 || almost_full !== 1'b0) $display("FAIL af_lvl2: got lvl=%0d af=%b want 2/0", level, almost_full);
    else passed++;
    wr_data = $urandom;
    tick();
    checks++;
    if (level !== 3'd3 || almost_full !== 1'b1) $display("FAIL af_lvl3: got lvl=%0d af=%b want 3/1", level, almost_full);
    else passed++;
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    checks++;
    if (level !== 3'd2 || almost_full !== 1'b0) $display("FAIL af_back2: got lvl=%0d af=%b want 2/0", level, almost_full);
    else passed++;
  endtask

  task automatic test_flush();
    wr_valid = 1'b1;
    wr_data  = $urandom;
    tick();  // level 3
    flush    = 1'b1;
    wr_data  = 32'h0BAD0BAD;
    tick();
    flush    = 1'b0;
    wr_valid = 1'b0;
    checks++;
    if (level !== 3'd0 || rd_valid !== 1'b0) $display("FAIL flush_clear: got lvl=%0d rv=%b want 0/0", level, rd_valid);
    else passed++;
    tick();
    checks++;
    if (rd_valid !== 1'b0) $display("FAIL flush_drop: got rv=%b want 0", rd_valid);
    else passed++;
  endtask

  task automatic test_async_reset();
    wr_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wr_data = 32'hC0DE0000 + k;
      tick();
    end
    wr_valid = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (level !== 3'd0 || rd_valid !== 1'b0 || wr_ready !== 1'b1 || almost_full !== 1'b0)
      $display("FAIL async_flags: got lvl=%0d rv=%b wr=%b af=%b want 0/0/1/0", level, rd_valid, wr_ready, almost_full);
    else passed++;
    checks++;
    if (wr_ptr_gray !== 3'b000 || rd_ptr_gray !== 3'b000)
      $display("FAIL async_ptrs: got %b/%b want 000/000", wr_ptr_gray, rd_ptr_gray);
    else passed++;
    exp_q.delete();
    m_wr_bin = '0;
    m_rd_bin = '0;
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    tick();
  endtask

  task automatic test_swap();
    s_wr_valid = 1'b1;
    s_wr_data  = 32'hAABBCCDD;
    @(posedge clk);
    #1;
    s_wr_valid = 1'b0;
    checks++;
    if (s_rd_valid !== 1'b1 || s_rd_data !== 32'hDDCCBBAA)
      $display("FAIL swap_word1: got rv=%b data=%h want 1/ddccbbaa", s_rd_valid, s_rd_data);
    else passed++;
    s_rd_ready = 1'b1;
    s_wr_valid = 1'b1;
    s_wr_data  = 32'h01020304;
    @(posedge clk);
    #1;
    s_rd_ready = 1'b0;
    s_wr_valid = 1'b0;
    checks++;
    if (s_rd_valid !== 1'b1 || s_rd_data !== 32'h04030201)
      $display("FAIL swap_word2: got rv=%b data=%h want 1/04030201", s_rd_valid, s_rd_data);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_almost_full();
    test_flush();
    test_swap();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
